// File: rtl/rom_arb_pkg.sv
// Shared constants for the ROM arbiter: parameter defaults, data width and FSM encoding.
package rom_arb_pkg;

   localparam int unsigned NPORT_DEF = 3;
   localparam int unsigned AW_DEF    = 24;
   localparam int unsigned TMO_DEF   = 255;
   localparam int unsigned DW        = 16;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first pending port after the last grant, wrapping around.
module rr_pick
   import rom_arb_pkg::*;
#(
   parameter int unsigned NPORT = NPORT_DEF,
   parameter int unsigned GW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
   input  logic [NPORT-1:0] i_pend,
   input  logic [GW-1:0]    i_last,
   output logic [GW-1:0]    o_pick
);

   // Walk offsets from farthest to nearest so the nearest pending port wins.
   always_comb begin
      o_pick = i_last;
      for (int i = int'(NPORT); i >= 1; i--) begin
         if (i_pend[GW'((int'(i_last) + i) % int'(NPORT))]) begin
            o_pick = GW'((int'(i_last) + i) % int'(NPORT));
         end
      end
   end

endmodule

// File: rtl/rom_arbiter.sv
// Multi-port ROM read arbiter in front of an SDRAM controller: edge/address-change
// request detection, round-robin grant, single outstanding access with timeout.
module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int unsigned NPORT = NPORT_DEF,
   parameter int unsigned AW    = AW_DEF,
   parameter int unsigned TMO   = TMO_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NPORT-1:0]    port_req,
   input  logic [NPORT*AW-1:0] port_addr,
   output logic [NPORT-1:0]    port_valid,
   output logic [DW-1:0]       port_data,
   output logic [NPORT-1:0]    port_err,
   output logic                sdram_req,
   output logic [AW-1:0]       sdram_addr,
   input  logic                sdram_ack,
   input  logic [DW-1:0]       sdram_data
);

   localparam int unsigned GW = (NPORT > 1) ? $clog2(NPORT) : 1;
   localparam int unsigned CW = $clog2(TMO + 1);

   logic [1:0]       r_state;
   logic [NPORT-1:0] r_req_q;
   logic [NPORT-1:0] r_pending;
   logic [AW-1:0]    r_last_addr [NPORT];
   logic [GW-1:0]    r_grant;
   logic [CW-1:0]    r_tmo;
   logic             r_drop;
   logic             r_stale;

   logic [AW-1:0]    w_addr [NPORT];
   logic [NPORT-1:0] w_detect;
   logic [GW-1:0]    w_pick;
   logic [1:0]       w_state_n;
   logic [GW-1:0]    w_grant_n;
   logic [NPORT-1:0] w_pending_n;
   logic [CW-1:0]    w_tmo_n;
   logic             w_drop_n;
   logic             w_stale_n;
   logic             w_sreq_n;
   logic [AW-1:0]    w_saddr_n;
   logic [DW-1:0]    w_data_n;
   logic [NPORT-1:0] w_valid_n;
   logic [NPORT-1:0] w_err_n;
   logic             w_last_wr;

   always_comb begin
      for (int p = 0; p < int'(NPORT); p++) begin
         w_addr[p] = port_addr[p*AW +: AW];
      end
   end

   // A request is new on a rising req, or on an address that differs from the one last issued.
   always_comb begin
      w_detect = '0;
      for (int p = 0; p < int'(NPORT); p++) begin
         w_detect[p] = port_req[p] && (!r_req_q[p] || (w_addr[p] != r_last_addr[p]));
      end
   end

   rr_pick #(
      .NPORT (NPORT),
      .GW    (GW)
   ) u_rr_pick (
      .i_pend (r_pending),
      .i_last (r_grant),
      .o_pick (w_pick)
   );

   // A re-request seen during WAIT/DONE marks the in-flight data stale and keeps the port pending.
   always_comb begin
      w_state_n   = r_state;
      w_grant_n   = r_grant;
      w_pending_n = r_pending | w_detect;
      w_tmo_n     = r_tmo;
      w_drop_n    = r_drop;
      w_stale_n   = r_stale;
      w_sreq_n    = sdram_req;
      w_saddr_n   = sdram_addr;
      w_data_n    = port_data;
      w_valid_n   = '0;
      w_err_n     = '0;
      w_last_wr   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|r_pending) begin
               w_grant_n = w_pick;
               w_state_n = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_saddr_n = w_addr[r_grant];
            w_sreq_n  = 1'b1;
            w_tmo_n   = '0;
            w_drop_n  = 1'b0;
            w_stale_n = 1'b0;
            w_last_wr = 1'b1;
            w_state_n = S_WAIT;
         end
         S_WAIT: begin
            if (!port_req[r_grant]) w_drop_n = 1'b1;
            if (w_detect[r_grant]) w_stale_n = 1'b1;
            if (sdram_ack) begin
               w_data_n  = sdram_data;
               w_sreq_n  = 1'b0;
               w_state_n = S_DONE;
            end else if (r_tmo == CW'(TMO - 1)) begin
               w_sreq_n          = 1'b0;
               w_err_n[r_grant]  = 1'b1;
               if (!(r_stale || w_detect[r_grant])) w_pending_n[r_grant] = 1'b0;
               w_state_n         = S_IDLE;
            end else begin
               w_tmo_n = r_tmo + CW'(1);
            end
         end
         S_DONE: begin
            if (!(r_stale || w_detect[r_grant])) begin
               w_pending_n[r_grant] = 1'b0;
               if (!r_drop && port_req[r_grant]) w_valid_n[r_grant] = 1'b1;
            end
            w_state_n = S_IDLE;
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_req_q    <= '0;
         r_pending  <= '0;
         r_grant    <= GW'(NPORT - 1);
         r_tmo      <= '0;
         r_drop     <= 1'b0;
         r_stale    <= 1'b0;
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         port_data  <= '0;
         port_valid <= '0;
         port_err   <= '0;
         for (int p = 0; p < int'(NPORT); p++) begin
            r_last_addr[p] <= '0;
         end
      end else begin
         r_state    <= w_state_n;
         r_req_q    <= port_req;
         r_pending  <= w_pending_n;
         r_grant    <= w_grant_n;
         r_tmo      <= w_tmo_n;
         r_drop     <= w_drop_n;
         r_stale    <= w_stale_n;
         sdram_req  <= w_sreq_n;
         sdram_addr <= w_saddr_n;
         port_data  <= w_data_n;
         port_valid <= w_valid_n;
         port_err   <= w_err_n;
         if (w_last_wr) r_last_addr[r_grant] <= w_addr[r_grant];
      end
   end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter NPORT, default 3, number of requester ports (port 0 = 68k program cache, 1 = Z80 sound ROM, 2 = sprite fetch).
REQ-002 Parameter AW, default 24, SDRAM word-address width.
REQ-003 Parameter TMO, default 255, cycles to wait for sdram_ack before aborting an access.
REQ-004 clk  in  1  system clock; all logic is clocked on the rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 port_req  in  NPORT  per-port request level, held high while the port wants data.
REQ-007 port_addr  in  NPORT*AW  per-port word address; port p occupies bits [p*AW +: AW].
REQ-008 port_valid  out  NPORT  one-cycle pulse per port when that port's data is ready.
REQ-009 port_data  out  16  read data, shared by all ports, qualified by port_valid.
REQ-010 port_err  out  NPORT  one-cycle pulse per port when its access timed out.
REQ-011 sdram_req  out  1  level request to the SDRAM controller.
REQ-012 sdram_addr  out  AW  address presented with sdram_req.
REQ-013 sdram_ack  in  1  one-cycle pulse: sdram_data holds valid data.
REQ-014 sdram_data  in  16  SDRAM read data.

Function
REQ-015 A new transaction on port p SHALL be detected when port_req[p] rises, or when port_addr[p] differs from that port's last-served address while port_req[p] is high; detection sets pending[p].
REQ-016 port_req[p] held high after port_valid[p] with an unchanged address SHALL NOT produce another transaction.
REQ-017 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE: if any pending bit is set, the arbiter SHALL grant one port round-robin, starting the search at the port after the last grant, and go to ISSUE next cycle.
REQ-019 ISSUE: latch the granted address into sdram_addr, assert sdram_req, clear the timeout counter, go to WAIT.
REQ-020 WAIT: sdram_req stays high; on sdram_ack, capture sdram_data into port_data, deassert sdram_req, go to DONE.
REQ-021 DONE: pulse port_valid[grant] for exactly one cycle, clear pending[grant], record the served address, return to IDLE.
REQ-022 Latency: from a pending bit set in IDLE with no contention to port_valid is 3 cycles plus the SDRAM ack latency.
REQ-023 If port_req[grant] falls during WAIT, the arbiter SHALL still complete the SDRAM access, suppress port_valid, and clear pending.
REQ-024 If the granted port's address changes during WAIT, the in-flight access SHALL complete without port_valid, and pending SHALL stay set so the new address is served later.
REQ-025 If the timeout counter reaches TMO in WAIT, the arbiter SHALL drop sdram_req, pulse port_err[grant] for one cycle, clear pending[grant], and return to IDLE.
REQ-026 A new request arriving on a port in the same cycle as its DONE SHALL be kept in pending, not lost.
REQ-027 port_data SHALL hold its last value between accesses.

Reset
REQ-028 While reset is low: FSM = IDLE, sdram_req = 0, sdram_addr = 0, port_valid = 0, port_err = 0, port_data = 0, pending = 0, last grant = NPORT-1 (so port 0 is searched first), timeout counter = 0.
REQ-029 Reset asserted mid-access SHALL abandon the access; any sdram_ack arriving after reset SHALL be ignored.

Structure
REQ-030 State encoding and the defaults for NPORT, AW and TMO SHALL live in a shared package, rom_arb_pkg.
REQ-031 The round-robin grant logic SHALL be one sub-module, rr_pick (inputs: pending mask, last grant; output: next grant index).

Verification
REQ-032 Single request: port 0 req rises with addr 0x000100, ack 4 cycles after sdram_req -> sdram_addr = 0x000100, exactly one port_valid[0] pulse, port_data equals ack data.
REQ-033 Contention: all 3 ports request in the same cycle -> grants in order 0, 1, 2; a second request from all three then grants in order 0, 1, 2 again.
REQ-034 Held request: port 0 keeps req high with an unchanged address for 20 cycles after valid -> no second sdram_req; changing the address to 0x000102 -> exactly one new access.
REQ-035 Timeout: sdram_ack held low (TMO = 255) -> sdram_req drops after 255 WAIT cycles, port_err pulses once, FSM returns to IDLE.
REQ-036 Abort: port 1 req drops during WAIT -> access completes on ack, no port_valid[1], and the next pending port is granted.
REQ-037 Reset mid-WAIT: reset low for 1 cycle, then a late ack -> no port_valid, all outputs at their reset values.
